// File: rtl/gen_scheduler_pkg.sv
// Shared types for the Game of Life generation scheduler: field selector and scheduler state.
package defs;

  typedef enum logic {
    FIELD_A = 1'b0,
    FIELD_B = 1'b1
  } field_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    GO       = 3'd2,
    WAIT_ACK = 3'd3,
    SIM      = 3'd4
  } sched_state_t;

endpackage

// File: rtl/gen_scheduler_if.sv
// Control, display-timing and next_field_iter handshake bundle for gen_scheduler.
// GEN_SCHED_LIMIT_EN adds the generation-limit input and limit-hit flag.
interface gen_scheduler_if
  import defs::*;
#(
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned GEN_W    = 16
);

  logic                i_run;
  logic                i_step;
  logic [PERIOD_W-1:0] i_period;
  logic                i_frame_start;
  logic                i_is_simulating;
  field_t              i_cur_read_field;
  logic                o_go;
  logic                o_busy;
  field_t              o_disp_field;
  logic [GEN_W-1:0]    o_gen_cnt;

`ifdef GEN_SCHED_LIMIT_EN
  logic [GEN_W-1:0]    i_gen_limit;
  logic                o_limit_hit;

  modport master (
    output i_run, i_step, i_period, i_frame_start, i_is_simulating, i_cur_read_field, i_gen_limit,
    input  o_go, o_busy, o_disp_field, o_gen_cnt, o_limit_hit
  );

  modport slave (
    input  i_run, i_step, i_period, i_frame_start, i_is_simulating, i_cur_read_field, i_gen_limit,
    output o_go, o_busy, o_disp_field, o_gen_cnt, o_limit_hit
  );
`else
  modport master (
    output i_run, i_step, i_period, i_frame_start, i_is_simulating, i_cur_read_field,
    input  o_go, o_busy, o_disp_field, o_gen_cnt
  );

  modport slave (
    input  i_run, i_step, i_period, i_frame_start, i_is_simulating, i_cur_read_field,
    output o_go, o_busy, o_disp_field, o_gen_cnt
  );
`endif

endinterface

// File: rtl/gen_scheduler_frame_period_cnt.sv
// Saturating count of frame starts since the last go, compared against the effective period.
module frame_period_cnt #(
  parameter int unsigned PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                frame_start,
  input  logic [PERIOD_W-1:0] period,
  output logic                o_period_done
);

  logic [PERIOD_W-1:0] frm_cnt;
  logic [PERIOD_W-1:0] period_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt <= '0;
    end else if (clear) begin
      frm_cnt <= '0;
    end else if (frame_start && (frm_cnt != '1)) begin
      frm_cnt <= frm_cnt + PERIOD_W'(1);
    end
  end

  // A zero period behaves as one frame per generation.
  assign period_eff    = (period == '0) ? PERIOD_W'(1) : period;
  assign o_period_done = (frm_cnt >= (period_eff - PERIOD_W'(1)));

endmodule

// File: rtl/gen_scheduler.sv
// Generation scheduler: issues next_field_iter go pulses on frame boundaries and keeps a tear-free display field.
// Optional GEN_SCHED_LIMIT_EN stops free-running once a programmed generation count is reached.
module gen_scheduler
  import defs::*;
#(
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned GEN_W    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  gen_scheduler_if.slave bus
);

  sched_state_t     state;
  sched_state_t     state_d;
  logic             step_armed;
  logic             step_armed_d;
  logic             inc_gen;
  logic             period_done;
  logic             run_armable;
  logic             go;
  logic             busy;
  field_t           disp_field;
  logic [GEN_W-1:0] gen_cnt;

  frame_period_cnt #(.PERIOD_W(PERIOD_W)) u_frame_period_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (state == GO),
    .frame_start   (bus.i_frame_start),
    .period        (bus.i_period),
    .o_period_done (period_done)
  );

`ifdef GEN_SCHED_LIMIT_EN
  logic limit_hit;
  logic run_q;

  // Limit-hit wins over a simultaneous run rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_hit <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_q <= bus.i_run;
      if (inc_gen && (bus.i_gen_limit != '0) && ((gen_cnt + GEN_W'(1)) == bus.i_gen_limit)) begin
        limit_hit <= 1'b1;
      end else if (bus.i_run && !run_q) begin
        limit_hit <= 1'b0;
      end
    end
  end

  assign run_armable     = bus.i_run && !limit_hit;
  assign bus.o_limit_hit = limit_hit;
`else
  assign run_armable = bus.i_run;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step_armed <= 1'b0;
    end else begin
      state      <= state_d;
      step_armed <= step_armed_d;
    end
  end

  // Step-armed ARM must survive i_run=0; run-armed ARM abandons on a run drop.
  always_comb begin
    state_d      = state;
    step_armed_d = step_armed;
    inc_gen      = 1'b0;
    case (state)
      IDLE: begin
        if (run_armable && period_done) begin
          state_d      = ARM;
          step_armed_d = 1'b0;
        end else if (!bus.i_run && bus.i_step) begin
          state_d      = ARM;
          step_armed_d = 1'b1;
        end
      end
      ARM: begin
        if (!step_armed && !bus.i_run) begin
          state_d = IDLE;
        end else if (bus.i_frame_start) begin
          state_d = GO;
        end
      end
      GO:       state_d = WAIT_ACK;
      WAIT_ACK: if (bus.i_is_simulating) state_d = SIM;
      SIM: begin
        if (!bus.i_is_simulating) begin
          state_d = IDLE;
          inc_gen = 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go         <= 1'b0;
      busy       <= 1'b0;
      gen_cnt    <= '0;
      disp_field <= FIELD_A;
    end else begin
      go   <= (state_d == GO);
      busy <= (state_d != IDLE);
      if (inc_gen) begin
        gen_cnt <= gen_cnt + GEN_W'(1);
      end
      if (bus.i_frame_start && !bus.i_is_simulating) begin
        disp_field <= bus.i_cur_read_field;
      end
    end
  end

  assign bus.o_go         = go;
  assign bus.o_busy       = busy;
  assign bus.o_gen_cnt    = gen_cnt;
  assign bus.o_disp_field = disp_field;

endmodule
